l1_refill_engine: RTL and testbench
===================================

# l1_refill_engine

Miss-side refill controller for the level-1 cache. It accepts a miss address from the cache, issues one line-aligned burst read to next-level memory, and writes each returned word into the L1 data array. On the last word it commits the tag and valid bit for the line. The critical (missed) word is forwarded to the requester as soon as it arrives.

## Interface
- `LINE_WORDS`, 8: 32-bit words per cache line (power of two).
- `INDEX_W`, 7: set-index width (128 sets).
- `ADDR_W`, 32: byte-address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `miss_valid` in 1: cache requests a refill.
- `miss_addr` in ADDR_W: byte address that missed.
- `miss_ready` out 1: high only in IDLE; request accepted when `miss_valid & miss_ready`.
- `mem_req_valid` out 1: burst read request to next level.
- `mem_req_addr` out ADDR_W: line-aligned address, low OFFSET_W bits zero.
- `mem_req_ready` in 1: next level accepts request.
- `mem_rsp_valid` in 1: one data beat; words return in order 0..LINE_WORDS-1.
- `mem_rsp_data` in 32: beat data.
- `fill_we` out 1: write one word into the data array.
- `fill_index` out INDEX_W: set index of the line being filled.
- `fill_word` out log2(LINE_WORDS): word offset within the line.
- `fill_data` out 32: word to write.
- `tag_we` out 1: write tag and set valid for `fill_index`.
- `tag_value` out TAG_W: tag, where TAG_W = ADDR_W - INDEX_W - OFFSET_W and OFFSET_W = log2(LINE_WORDS) + 2.
- `fwd_valid` out 1: one-cycle pulse carrying the critical word.
- `fwd_data` out 32: critical word.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Address split:**
  - offset = `addr[OFFSET_W-1:0]`
  - index = `addr[OFFSET_W+INDEX_W-1:OFFSET_W]`
  - tag = upper bits
  - critical word = `addr[OFFSET_W-1:2]`
- **IDLE:** `miss_ready`=1. On acceptance, latch the address into `line_addr_q` and go to REQ.
- **REQ:** `mem_req_valid`=1 with a stable address. On `mem_req_ready`, clear the beat counter and go to FILL.
- **FILL:** each `mem_rsp_valid` beat increments the beat counter (`beat_q`).
  - One cycle later: `fill_we`=1, `fill_word`=`beat_q`, `fill_data`=the beat.
  - If `beat_q` equals the critical word, `fwd_valid`=1 in the same cycle as the corresponding `fill_we`.
  - On the beat where `beat_q`=LINE_WORDS-1, go to COMMIT.
- **COMMIT:** `tag_we`=1 for exactly one cycle, then return to IDLE.
- **Beat counter:** width log2(LINE_WORDS); wraps to 0 on the last beat. No other arithmetic.
- **Output hold:** `fill_index`, `tag_value` and `mem_req_addr` derive from `line_addr_q` and hold for the whole refill.
- **Boundary conditions:**
  - `miss_valid` while busy: not accepted; the cache holds it.
  - `mem_rsp_valid` in IDLE, REQ or COMMIT: ignored, no write.
  - `miss_valid` in the COMMIT cycle: not accepted. It is accepted in the following IDLE cycle at the earliest.
  - Gaps between beats: permitted, any length.
  - `rst` mid-refill: return to IDLE immediately. `tag_we` is never issued, so the line stays invalid. Partial data words are harmless.

## Timing
- **Reset values:** all outputs 0 except `miss_ready`=1. State IDLE, counters 0.
- All outputs are registered or decoded from the state register; there is no combinational path from an input to an output.
- **Request latency:** miss accepted at edge T → `mem_req_valid` high from T+1.
- **Write latency:** beat sampled at edge B → `fill_we`/`fwd_valid` high in cycle B+1.
- **Commit:** the last beat at edge L gives the last `fill_we` at L+1 and `tag_we` at L+1. The data write and the tag write land in the same cycle.
- **Back-to-back refills:** `miss_ready` returns at L+2.
- **Minimum refill:** 1 (REQ) + LINE_WORDS + 1 (COMMIT) cycles plus memory latency.

## Structure
- Shared package `l1_cache_pkg` holds:
  - `ADDR_W`, `INDEX_W`, `LINE_WORDS`, `OFFSET_W`, `TAG_W`
  - the state enum (IDLE, REQ, FILL, COMMIT)
  - address-field extraction functions, also used by the L1 array and hit logic.
- Single module; no sub-module is warranted.

## Test plan
- **Basic refill:** miss_addr=0x0001_2344, `mem_req_ready` immediate, beats 0xA0..0xA7 contiguous.
  - `mem_req_addr`=0x0001_2340.
  - `fill_index`=0x1A, `tag_value`=0x00012.
  - 8 `fill_we` with words 0..7.
  - `fwd_data`=0xA1.
  - `tag_we` coincides with word 7.
- **Stalled handshake:** `mem_req_ready` held low for 5 cycles, 2-cycle gaps between beats.
  - `mem_req_valid` and its address stay stable.
  - Exactly 8 writes, in order.
  - `busy` stays high throughout.
- **Critical word last:** miss_addr offset 0x1C → `fwd_valid` on word 7, in the same cycle as `tag_we`.
- **Stray beats:** `mem_rsp_valid` pulsed in IDLE and in REQ → no `fill_we`, beat count unaffected.
  - A second `miss_valid` during FILL is not accepted until IDLE.
- **Reset mid-fill:** `rst` asserted after beat 3.
  - All outputs go to reset values asynchronously.
  - No `tag_we`.
  - A new miss then completes a normal refill.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// ============================================================================
//  Module      : l1_cache_pkg
//  Description : Shared L1 geometry, refill state encoding and address-field
//                extraction helpers used by the refill engine, array and hit
//                logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package l1_cache_pkg;

    localparam int ADDR_W     = 32;
    localparam int INDEX_W    = 7;
    localparam int LINE_WORDS = 8;
    localparam int WORD_W     = 32;
    localparam int WORD_SEL_W = $clog2(LINE_WORDS);
    localparam int OFFSET_W   = WORD_SEL_W + 2;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_FILL   = 2'd2,
        ST_COMMIT = 2'd3
    } refill_state_e;

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFFSET_W+INDEX_W];
    endfunction

    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:2];
    endfunction

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/l1_refill_engine.sv
// ============================================================================
//  Module      : l1_refill_engine
//  Description : L1 miss refill controller: one line-aligned burst read,
//                per-word data-array writes, critical-word forward, tag commit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_refill_engine
    import l1_cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    input  logic [ADDR_W-1:0]     miss_addr,
    output logic                  miss_ready,
    output logic                  mem_req_valid,
    output logic [ADDR_W-1:0]     mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [WORD_W-1:0]     mem_rsp_data,
    output logic                  fill_we,
    output logic [INDEX_W-1:0]    fill_index,
    output logic [WORD_SEL_W-1:0] fill_word,
    output logic [WORD_W-1:0]     fill_data,
    output logic                  tag_we,
    output logic [TAG_W-1:0]      tag_value,
    output logic                  fwd_valid,
    output logic [WORD_W-1:0]     fwd_data,
    output logic                  busy
);

    localparam logic [WORD_SEL_W-1:0] c_LAST_BEAT = WORD_SEL_W'(LINE_WORDS - 1);

    refill_state_e          r_state;
    refill_state_e          w_state_next;
    logic [ADDR_W-1:0]      r_line_addr;
    logic [WORD_SEL_W-1:0]  r_beat;
    logic                   r_fill_we;
    logic [WORD_SEL_W-1:0]  r_fill_word;
    logic [WORD_W-1:0]      r_fill_data;
    logic                   r_fwd_valid;
    logic [WORD_W-1:0]      r_fwd_data;

    logic                   w_accept;
    logic                   w_req_done;
    logic                   w_beat;
    logic                   w_last_beat;

    assign w_accept    = miss_valid & (r_state == ST_IDLE);
    assign w_req_done  = mem_req_ready & (r_state == ST_REQ);
    assign w_beat      = mem_rsp_valid & (r_state == ST_FILL);
    assign w_last_beat = w_beat & (r_beat == c_LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_accept)    w_state_next = ST_REQ;
            ST_REQ:    if (w_req_done)  w_state_next = ST_FILL;
            ST_FILL:   if (w_last_beat) w_state_next = ST_COMMIT;
            ST_COMMIT:                  w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    // Write strobes are single-cycle; data fields hold until the next beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_addr <= '0;
            r_beat      <= '0;
            r_fill_we   <= 1'b0;
            r_fill_word <= '0;
            r_fill_data <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_data  <= '0;
        end else begin
            r_fill_we   <= 1'b0;
            r_fwd_valid <= 1'b0;
            if (w_accept) begin
                r_line_addr <= miss_addr;
            end
            if (w_req_done) begin
                r_beat <= '0;
            end
            if (w_beat) begin
                r_beat      <= r_beat + 1'b1;
                r_fill_we   <= 1'b1;
                r_fill_word <= r_beat;
                r_fill_data <= mem_rsp_data;
                if (r_beat == addr_word(r_line_addr)) begin
                    r_fwd_valid <= 1'b1;
                    r_fwd_data  <= mem_rsp_data;
                end
            end
        end
    end

    assign miss_ready    = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign mem_req_valid = (r_state == ST_REQ);
    assign tag_we        = (r_state == ST_COMMIT);
    assign mem_req_addr  = line_align(r_line_addr);
    assign fill_index    = addr_index(r_line_addr);
    assign tag_value     = addr_tag(r_line_addr);
    assign fill_we       = r_fill_we;
    assign fill_word     = r_fill_word;
    assign fill_data     = r_fill_data;
    assign fwd_valid     = r_fwd_valid;
    assign fwd_data      = r_fwd_data;

endmodule

`default_nettype wire

// File: tb/tb_l1_refill_engine.sv
// ============================================================================
//  Module      : tb_l1_refill_engine
//  Description : Self-checking bench for l1_refill_engine with a line-level
//                reference model and randomized refills.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l1_refill_engine;
    import l1_cache_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  miss_valid;
    logic [ADDR_W-1:0]     miss_addr;
    logic                  miss_ready;
    logic                  mem_req_valid;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_req_ready;
    logic                  mem_rsp_valid;
    logic [WORD_W-1:0]     mem_rsp_data;
    logic                  fill_we;
    logic [INDEX_W-1:0]    fill_index;
    logic [WORD_SEL_W-1:0] fill_word;
    logic [WORD_W-1:0]     fill_data;
    logic                  tag_we;
    logic [TAG_W-1:0]      tag_value;
    logic                  fwd_valid;
    logic [WORD_W-1:0]     fwd_data;
    logic                  busy;

    l1_refill_engine u_dut (
        .clk           (clk),
        .rst           (rst),
        .miss_valid    (miss_valid),
        .miss_addr     (miss_addr),
        .miss_ready    (miss_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .fill_we       (fill_we),
        .fill_index    (fill_index),
        .fill_word     (fill_word),
        .fill_data     (fill_data),
        .tag_we        (tag_we),
        .tag_value     (tag_value),
        .fwd_valid     (fwd_valid),
        .fwd_data      (fwd_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [41:0] exp_wr[$];
    logic [41:0] mon_e;
    logic [31:0] exp_fwd;
    logic [2:0]  exp_crit;
    logic [26:0] exp_tagidx;
    bit          fwd_armed = 1'b0;
    bit          tag_armed = 1'b0;
    int          fwd_cnt = 0;
    int          tag_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference address split, expressed with plain arithmetic on the byte address.
    function automatic logic [6:0]  m_index(input logic [31:0] a); return 7'((a / 32) % 128); endfunction
    function automatic logic [19:0] m_tag  (input logic [31:0] a); return 20'(a / 4096);      endfunction
    function automatic logic [31:0] m_line (input logic [31:0] a); return a - (a % 32);       endfunction
    function automatic logic [2:0]  m_crit (input logic [31:0] a); return 3'((a % 32) / 4);   endfunction

    task automatic check_reset(input string tag);
        check_eq({tag, "_ctl"},  64'({miss_ready, mem_req_valid, fill_we, tag_we, fwd_valid, busy}), 64'(6'b100000));
        check_eq({tag, "_addr"}, 64'({mem_req_addr, fill_index, fill_word}), 64'd0);
        check_eq({tag, "_data"}, {fill_data, fwd_data}, 64'd0);
        check_eq({tag, "_tag"},  64'(tag_value), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (fill_we) begin
                if (exp_wr.size() == 0) begin
                    check_eq("wr_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check_eq("fill_write", 64'({fill_index, fill_word, fill_data}), 64'(mon_e));
                end
            end
            if (fwd_valid) begin
                fwd_cnt++;
                if (!fwd_armed) check_eq("fwd_unexpected", 64'd1, 64'd0);
                else check_eq("fwd_word_data", 64'({fill_we, fill_word, fwd_data}), 64'({1'b1, exp_crit, exp_fwd}));
            end
            if (tag_we) begin
                tag_cnt++;
                if (!tag_armed) check_eq("tag_unexpected", 64'd1, 64'd0);
                else check_eq("tag_commit", 64'({fill_we, fill_word, fill_index, tag_value}),
                              64'({1'b1, 3'd7, exp_tagidx}));
            end
        end
    end

    task automatic do_refill(input logic [31:0] addr, input int req_delay, input int gap_lo, input int gap_hi,
                             input bit stray, input int rst_after, input bit hold_next,
                             input logic [31:0] next_addr, input bit fixed_data);
        logic [31:0] d [LINE_WORDS];
        int          n;
        for (int k = 0; k < LINE_WORDS; k++) d[k] = fixed_data ? (32'hA0 + 32'(k)) : $urandom;
        fwd_cnt = 0;
        tag_cnt = 0;
        if (!miss_valid && stray) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = $urandom;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            check_eq("idle_stray", 64'({busy, fill_we}), 64'd0);
        end
        miss_valid = 1'b1;
        miss_addr  = addr;
        n = 0;
        while (miss_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            check_eq("timeout_miss_ready", 64'd0, 64'd1);
            miss_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        miss_valid = 1'b0;
        check_eq("req_start", 64'({mem_req_valid, miss_ready, busy}), 64'(3'b101));
        check_eq("req_addr", 64'(mem_req_addr), 64'(m_line(addr)));
        check_eq("idx_tag", 64'({fill_index, tag_value}), 64'({m_index(addr), m_tag(addr)}));
        for (int i = 0; i < req_delay; i++) begin
            mem_req_ready = 1'b0;
            if (stray && i == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = $urandom;
            end
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            check_eq("req_stall", 64'({mem_req_valid, busy, mem_req_addr}), 64'({2'b11, m_line(addr)}));
        end
        for (int k = 0; k < LINE_WORDS; k++) exp_wr.push_back({m_index(addr), 3'(k), d[k]});
        exp_crit   = m_crit(addr);
        exp_fwd    = d[exp_crit];
        exp_tagidx = {m_index(addr), m_tag(addr)};
        fwd_armed  = 1'b1;
        tag_armed  = 1'b1;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        check_eq("fill_entry", 64'({mem_req_valid, busy, fill_we}), 64'(3'b010));
        for (int k = 0; k < LINE_WORDS; k++) begin
            n = $urandom_range(gap_hi, gap_lo);
            repeat (n) begin
                @(posedge clk); #1;
                check_eq("gap_idle", 64'({fill_we, busy}), 64'(2'b01));
            end
            if (hold_next) begin
                miss_valid = 1'b1;
                miss_addr  = next_addr;
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = d[k];
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            check_eq("beat_write", 64'({fill_we, fill_word, fill_data}), 64'({1'b1, 3'(k), d[k]}));
            check_eq("fwd_timing", 64'(fwd_valid), 64'(3'(k) == exp_crit));
            if (hold_next) check_eq("busy_no_accept", 64'({miss_ready, mem_req_valid}), 64'd0);
            if (k == rst_after) begin
                rst = 1'b1;
                #1;
                check_reset("rst_async");
                exp_wr.delete();
                fwd_armed = 1'b0;
                tag_armed = 1'b0;
                @(posedge clk); #1;
                check_eq("rst_no_tag", 64'(tag_we), 64'd0);
                rst = 1'b0;
                miss_valid = 1'b0;
                return;
            end
        end
        check_eq("commit", 64'({tag_we, miss_ready, mem_req_valid, busy}), 64'(4'b1001));
        @(posedge clk); #1;
        check_eq("back_to_idle", 64'({miss_ready, busy, tag_we, fill_we}), 64'(4'b1000));
        check_eq("writes_drained", 64'(exp_wr.size()), 64'd0);
        check_eq("fwd_once", 64'(fwd_cnt), 64'd1);
        check_eq("tag_once", 64'(tag_cnt), 64'd1);
        fwd_armed = 1'b0;
        tag_armed = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a [20];
        logic [31:0] nxt;
        int          rd;
        bit          st;
        bit          hold;
        rst           = 1'b1;
        miss_valid    = 1'b0;
        miss_addr     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        #1;
        check_reset("rst_init");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("post_rst");

        do_refill(32'h0001_2344, 0, 0, 0, 1'b0, -1, 1'b0, 32'h0, 1'b1);
        do_refill(32'h0BAD_F00C, 5, 2, 2, 1'b0, -1, 1'b0, 32'h0, 1'b0);
        do_refill(32'h4000_0A1C, 0, 0, 1, 1'b0, -1, 1'b0, 32'h0, 1'b0);
        do_refill(32'h7654_3210, 2, 0, 2, 1'b1, -1, 1'b1, 32'h1357_9BD8, 1'b0);
        do_refill(32'h1357_9BD8, 1, 0, 1, 1'b1, -1, 1'b0, 32'h0, 1'b0);
        do_refill(32'hCAFE_BA64, 0, 0, 1, 1'b0, 3, 1'b0, 32'h0, 1'b0);
        do_refill(32'hCAFE_BA64, 0, 0, 0, 1'b0, -1, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 20; i++) a[i] = $urandom;
        for (int i = 0; i < 20; i++) begin
            rd   = $urandom_range(4, 0);
            st   = (rd >= 1) && ($urandom_range(1, 0) == 1);
            hold = (i < 19) && ($urandom_range(1, 0) == 1);
            nxt  = (i < 19) ? a[(i + 1) % 20] : 32'h0;
            do_refill(a[i], rd, 0, 3, st, -1, hold, nxt, 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
